clock_set_ctrl: RTL and testbench

- Button-driven editor for the decade clock's time and date registers; the writer side of the clock/calendar counter.
- Conditions the three raw push-buttons and steps through the fields of the current display mode.
- Increments/decrements the selected field with calendar-correct wrap.
- Issues a one-cycle load strobe, with the new values, to the counter.

---
 rtl/clock_pkg.sv | 59 +++++
 rtl/button_conditioner.sv | 41 ++++
 rtl/clock_set_ctrl.sv | 131 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock/calendar definitions: field encoding, limits, reset date and
// the calendar helpers used by both the set controller and the counter.
package clock_pkg;

    typedef enum logic [2:0] {
        F_NONE  = 3'd0,
        F_HOUR  = 3'd1,
        F_MIN   = 3'd2,
        F_SEC   = 3'd3,
        F_DAY   = 3'd4,
        F_MONTH = 3'd5,
        F_YEAR  = 3'd6
    } field_e;

    localparam int HOUR_MAX  = 23;
    localparam int MIN_MAX   = 59;
    localparam int MONTH_MAX = 12;
    localparam int YEAR_MAX  = 9999;

    localparam logic [4:0]  RST_DAY   = 5'd1;
    localparam logic [3:0]  RST_MONTH = 4'd1;
    localparam logic [13:0] RST_YEAR  = 14'd2024;

    function automatic logic is_leap(input logic [13:0] year);
        return (((year % 14'd4) == 14'd0) && ((year % 14'd100) != 14'd0)) ||
               ((year % 14'd400) == 14'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic [13:0] year);
        logic [4:0] d;
        case (month)
            4'd2:                    d = is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // One step up or down inside [lo, hi], done one bit wider than any field
    // so the overflow compare never sees a modulo wrap. Out-of-range values
    // snap back into range.
    function automatic logic [14:0] wrap_step(input logic [14:0] v,
                                              input logic        up,
                                              input logic [14:0] lo,
                                              input logic [14:0] hi);
        logic [14:0] n;
        if (up) begin
            n = v + 15'd1;
            if (n > hi) n = lo;
        end else begin
            if (v <= lo)     n = hi;
            else if (v > hi) n = hi;
            else             n = v - 15'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle press event: 2-flop synchronizer, counting
// debounce, and a pulse on the debounced rising edge only.
module button_conditioner #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            // Any sample agreeing with the current level restarts the count.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time/date editor: walks the fields of the current mode, steps
// the selected field with calendar-correct wrap, and strobes a load on exit.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic [4:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic [5:0]  cur_sec,
    input  logic [4:0]  cur_day,
    input  logic [3:0]  cur_month,
    input  logic [13:0] cur_year,
    output logic        edit_active,
    output logic [2:0]  edit_field,
    output logic [4:0]  set_hour,
    output logic [5:0]  set_min,
    output logic [5:0]  set_sec,
    output logic [4:0]  set_day,
    output logic [3:0]  set_month,
    output logic [13:0] set_year,
    output logic        load_time,
    output logic        load_date
);

    localparam logic [2:0] IDLE    = F_NONE;
    localparam logic [2:0] E_HOUR  = F_HOUR;
    localparam logic [2:0] E_MIN   = F_MIN;
    localparam logic [2:0] E_SEC   = F_SEC;
    localparam logic [2:0] E_DAY   = F_DAY;
    localparam logic [2:0] E_MONTH = F_MONTH;
    localparam logic [2:0] E_YEAR  = F_YEAR;

    logic        chg_ev, inc_ev, dec_ev;
    logic [2:0]  state;
    logic        edit_mode;
    logic [4:0]  hour_nxt, day_nxt, dim_cur, day_lim_m, day_lim_y;
    logic [5:0]  min_nxt, sec_nxt;
    logic [3:0]  month_nxt;
    logic [13:0] year_nxt;

    button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_chg (
        .clk(clk), .rst_n(rst_n), .raw(butt_change), .press(chg_ev)
    );
    button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_inc (
        .clk(clk), .rst_n(rst_n), .raw(butt_increase), .press(inc_ev)
    );
    button_conditioner #(.DB_CYCLES(DB_CYCLES)) u_dec (
        .clk(clk), .rst_n(rst_n), .raw(butt_decrease), .press(dec_ev)
    );

    assign edit_field  = state;
    assign edit_active = (state != IDLE);

    always_comb begin
        dim_cur   = days_in_month(set_month, set_year);
        hour_nxt  = 5'(wrap_step(15'(set_hour), inc_ev, 15'd0, 15'(HOUR_MAX)));
        min_nxt   = 6'(wrap_step(15'(set_min), inc_ev, 15'd0, 15'(MIN_MAX)));
        sec_nxt   = 6'(wrap_step(15'(set_sec), inc_ev, 15'd0, 15'(MIN_MAX)));
        day_nxt   = 5'(wrap_step(15'(set_day), inc_ev, 15'd1, 15'(dim_cur)));
        month_nxt = 4'(wrap_step(15'(set_month), inc_ev, 15'd1, 15'(MONTH_MAX)));
        year_nxt  = 14'(wrap_step(15'(set_year), inc_ev, 15'd0, 15'(YEAR_MAX)));
        // Month/year edits can shrink the month under the current day.
        day_lim_m = days_in_month(month_nxt, set_year);
        day_lim_y = days_in_month(set_month, year_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            edit_mode <= 1'b0;
            load_time <= 1'b0;
            load_date <= 1'b0;
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
            set_day   <= RST_DAY;
            set_month <= RST_MONTH;
            set_year  <= RST_YEAR;
        end else begin
            load_time <= 1'b0;
            load_date <= 1'b0;
            if (state != IDLE && mode != edit_mode) begin
                state <= IDLE;
            end else if (chg_ev) begin
                case (state)
                    IDLE: begin
                        set_hour  <= cur_hour;
                        set_min   <= cur_min;
                        set_sec   <= cur_sec;
                        set_day   <= cur_day;
                        set_month <= cur_month;
                        set_year  <= cur_year;
                        edit_mode <= mode;
                        state     <= mode ? E_DAY : E_HOUR;
                    end
                    E_HOUR:  state <= E_MIN;
                    E_MIN:   state <= E_SEC;
                    E_SEC:   begin state <= IDLE; load_time <= 1'b1; end
                    E_DAY:   state <= E_MONTH;
                    E_MONTH: state <= E_YEAR;
                    E_YEAR:  begin state <= IDLE; load_date <= 1'b1; end
                    default: state <= IDLE;
                endcase
            end else if (inc_ev ^ dec_ev) begin
                case (state)
                    E_HOUR: set_hour <= hour_nxt;
                    E_MIN:  set_min  <= min_nxt;
                    E_SEC:  set_sec  <= sec_nxt;
                    E_DAY:  set_day  <= day_nxt;
                    E_MONTH: begin
                        set_month <= month_nxt;
                        if (set_day > day_lim_m) set_day <= day_lim_m;
                    end
                    E_YEAR: begin
                        set_year <= year_nxt;
                        if (set_day > day_lim_y) set_day <= day_lim_y;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed calendar cases followed by
// random button sequences against a modular-arithmetic calendar model.
module tb_clock_set_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        b_inc = 1'b0, b_dec = 1'b0, b_chg = 1'b0;
    logic [4:0]  cur_hour = '0;
    logic [5:0]  cur_min = '0, cur_sec = '0;
    logic [4:0]  cur_day = 5'd1;
    logic [3:0]  cur_month = 4'd1;
    logic [13:0] cur_year = 14'd2024;
    logic        edit_active, load_time, load_date;
    logic [2:0]  edit_field;
    logic [4:0]  set_hour, set_day;
    logic [5:0]  set_min, set_sec;
    logic [3:0]  set_month;
    logic [13:0] set_year;

    always #5 clk = ~clk;

    clock_set_ctrl #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .butt_increase(b_inc), .butt_decrease(b_dec), .butt_change(b_chg),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .edit_active(edit_active), .edit_field(edit_field),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .load_time(load_time), .load_date(load_date)
    );

    int errors = 0, checks = 0;
    int lt_cnt = 0, ld_cnt = 0;
    logic [16:0] lt_snap = '0;
    logic [22:0] ld_snap = '0;

    // Every cycle a strobe is high counts, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (load_time) begin
            lt_cnt  <= lt_cnt + 1;
            lt_snap <= {set_hour, set_min, set_sec};
        end
        if (load_date) begin
            ld_cnt  <= ld_cnt + 1;
            ld_snap <= {set_day, set_month, set_year};
        end
    end

    int m_f, m_h, m_mi, m_s, m_d, m_mo, m_y, m_lt = 0, m_ld = 0;

    function automatic int mdim(input int mo, input int y);
        bit leap;
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        case (mo)
            2:           return leap ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":field"},  32'(edit_field), m_f);
        chk({tag, ":active"}, 32'(edit_active), 32'(m_f != 0));
        chk({tag, ":hour"},   32'(set_hour), m_h);
        chk({tag, ":min"},    32'(set_min), m_mi);
        chk({tag, ":sec"},    32'(set_sec), m_s);
        chk({tag, ":day"},    32'(set_day), m_d);
        chk({tag, ":month"},  32'(set_month), m_mo);
        chk({tag, ":year"},   32'(set_year), m_y);
        chk({tag, ":lt_cnt"}, lt_cnt, m_lt);
        chk({tag, ":ld_cnt"}, ld_cnt, m_ld);
    endtask

    task automatic model_step(input bit c, input bit i, input bit d);
        int dl, n;
        dl = i ? 1 : -1;
        if (c) begin
            case (m_f)
                0: begin
                    m_h = cur_hour; m_mi = cur_min; m_s = cur_sec;
                    m_d = cur_day;  m_mo = cur_month; m_y = cur_year;
                    m_f = mode ? 4 : 1;
                end
                3: begin m_f = 0; m_lt++; end
                6: begin m_f = 0; m_ld++; end
                default: m_f++;
            endcase
        end else if (i != d && m_f != 0) begin
            case (m_f)
                1: m_h  = (m_h + 24 + dl) % 24;
                2: m_mi = (m_mi + 60 + dl) % 60;
                3: m_s  = (m_s + 60 + dl) % 60;
                4: begin n = mdim(m_mo, m_y); m_d = (m_d - 1 + n + dl) % n + 1; end
                5: m_mo = (m_mo - 1 + 12 + dl) % 12 + 1;
                default: m_y = (m_y + 10000 + dl) % 10000;
            endcase
            if (m_d > mdim(m_mo, m_y)) m_d = mdim(m_mo, m_y);
        end
    endtask

    task automatic press(input bit c, input bit i, input bit d, input string tag);
        int plt, pld;
        plt = m_lt; pld = m_ld;
        @(negedge clk); b_chg = c; b_inc = i; b_dec = d;
        repeat (DB + 6) @(negedge clk);
        b_chg = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
        repeat (DB + 6) @(negedge clk);
        model_step(c, i, d);
        check_all(tag);
        if (m_lt != plt) chk({tag, ":lt_vals"}, 32'(lt_snap), (m_h << 12) | (m_mi << 6) | m_s);
        if (m_ld != pld) chk({tag, ":ld_vals"}, 32'(ld_snap), (m_d << 18) | (m_mo << 14) | m_y);
    endtask

    task automatic set_cur(input int h, input int mi, input int s, input int d, input int mo, input int y);
        @(negedge clk);
        cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
        cur_day = 5'(d); cur_month = 4'(mo); cur_year = 14'(y);
    endtask

    task automatic toggle_mode(input string tag);
        @(negedge clk); mode = ~mode;
        repeat (3) @(negedge clk);
        m_f = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); rst_n = 1'b0; b_chg = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
        repeat (2) @(negedge clk);
        m_f = 0; m_h = 0; m_mi = 0; m_s = 0; m_d = 1; m_mo = 1; m_y = 2024;
        check_all({tag, ":in_reset"});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all({tag, ":after"});
    endtask

    initial begin
        int r, y, mo;
        do_reset("reset");

        @(negedge clk); b_chg = 1'b1;
        repeat (2) @(negedge clk); b_chg = 1'b0;
        repeat (12) @(negedge clk);
        check_all("glitch");

        // time edit: 23:59:30 -> 00:58:30
        set_cur(23, 59, 30, 15, 6, 2024);
        press(1, 0, 0, "t_enter"); press(0, 1, 0, "t_hinc");
        press(1, 0, 0, "t_min");   press(0, 0, 1, "t_mdec");
        press(1, 0, 0, "t_sec");   press(1, 0, 0, "t_exit");
        chk("t_load_once", lt_cnt, 1);
        chk("t_load_vals", 32'(lt_snap), 32'({5'd0, 6'd58, 6'd30}));
        chk("t_no_date", ld_cnt, 0);

        // date edit with Feb clamps
        @(negedge clk); mode = 1'b1;
        set_cur(0, 0, 0, 31, 1, 2024);
        press(1, 0, 0, "d_enter"); press(1, 0, 0, "d_month"); press(0, 1, 0, "d_minc");
        chk("d_clamp29", 32'(set_day), 29);
        press(1, 0, 0, "d_year"); press(0, 1, 0, "d_yinc");
        chk("d_clamp28", 32'(set_day), 28);
        press(1, 0, 0, "d_exit");
        chk("d_load_once", ld_cnt, 1);
        chk("d_load_vals", 32'(ld_snap), 32'({5'd28, 4'd2, 14'd2025}));

        // wraps
        set_cur(0, 0, 0, 15, 12, 9999);
        press(1, 0, 0, "w_enter"); press(1, 0, 0, "w_month"); press(0, 1, 0, "w_m12inc");
        chk("w_month1", 32'(set_month), 1);
        press(1, 0, 0, "w_year"); press(0, 1, 0, "w_y9999inc");
        chk("w_year0", 32'(set_year), 0);
        press(0, 0, 1, "w_y0dec");
        chk("w_year9999", 32'(set_year), 9999);
        press(1, 0, 0, "w_exit");
        set_cur(0, 0, 0, 1, 4, 2100);
        press(1, 0, 0, "w_d2100"); press(0, 0, 1, "w_d1dec");
        chk("w_day30", 32'(set_day), 30);
        toggle_mode("w_abort1"); toggle_mode("w_back1");
        set_cur(0, 0, 0, 29, 2, 2000);
        press(1, 0, 0, "w_d2000"); press(0, 0, 1, "w_d29dec");
        chk("w_day28", 32'(set_day), 28);
        toggle_mode("w_abort2");

        // simultaneous buttons, then abort in E_MIN, then reset in E_MONTH
        set_cur(10, 20, 30, 5, 5, 2020);
        press(1, 0, 0, "s_enter"); press(1, 0, 0, "s_min");
        press(0, 1, 1, "s_incdec");
        chk("s_min_hold", 32'(set_min), 20);
        press(1, 1, 0, "s_chginc");
        chk("s_field_sec", 32'(edit_field), 3);
        chk("s_min_hold2", 32'(set_min), 20);
        toggle_mode("s_abort_sec"); toggle_mode("s_mode0");
        press(1, 0, 0, "a_enter"); press(1, 0, 0, "a_min");
        toggle_mode("a_abort_min");
        chk("a_no_strobe", lt_cnt, 1);
        press(1, 0, 0, "r_enter"); press(1, 0, 0, "r_month");
        do_reset("r_mid_edit");
        chk("r_no_strobe", ld_cnt, 2);

        for (int k = 0; k < 150; k++) begin
            if (m_f == 0 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0: y = 0; 1: y = 9999; 2: y = 2000; 3: y = 2100;
                    default: y = $urandom_range(0, 9999);
                endcase
                mo = $urandom_range(1, 12);
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                        $urandom_range(1, mdim(mo, y)), mo, y);
            end
            r = $urandom_range(0, 99);
            if (r < 35)      press(1, 0, 0, "rnd_chg");
            else if (r < 60) press(0, 1, 0, "rnd_inc");
            else if (r < 85) press(0, 0, 1, "rnd_dec");
            else if (r < 90) press(0, 1, 1, "rnd_incdec");
            else if (r < 96) press(1, r[0], ~r[0], "rnd_chgstep");
            else             toggle_mode("rnd_mode");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
